// File: rtl/mux_pkg.sv
// Shared types for the registered scanning multiplexer.
package mux_pkg;

    // Externally requested operating mode, decoded from the mode pin.
    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    // Internal controller state, tracks the mode seen on the previous edge.
    typedef enum logic {
        S_MANUAL = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

endpackage

// File: rtl/mux_scan_next.sv
// Combinational round-robin finder: returns the first enabled channel strictly
// after cur (wrapping modulo NUM_CH, cur itself being the last candidate).
module mux_scan_next #(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [SEL_W-1:0]  cur,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  next_idx,
    output logic              found,
    output logic              wrapped
);

    // Scan candidates from farthest to nearest so the nearest enabled one wins.
    always_comb begin
        int idx;
        next_idx = cur;
        found    = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(cur) + i) % NUM_CH;
            if (mask[idx]) begin
                next_idx = SEL_W'(idx);
                found    = 1'b1;
            end else begin
                found    = found;
            end
        end
        wrapped = found && (next_idx <= cur);
    end

endmodule

// File: rtl/mux_scan.sv
// N-channel registered multiplexer with manual select and round-robin scan.
module mux_scan #(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 1,
    parameter  int DWELL  = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    hold,
    input  logic [NUM_CH-1:0]       ch_mask,
    output logic [WIDTH-1:0]        data_out,
    output logic [SEL_W-1:0]        cur_ch,
    output logic                    valid,
    output logic                    wrap
);

    import mux_pkg::*;

    localparam int             CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_ch_q, ch_next_s;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SEL_W-1:0]   find_idx_s;
    logic               find_ok_s;
    logic               find_wrap_s;
    logic               sel_ok_s;

    // Widened compare so a non-power-of-two channel count can flag sel out of range.
    assign sel_ok_s = ({1'b0, sel} < (SEL_W + 1)'(NUM_CH));

    mux_scan_next #(
        .NUM_CH (NUM_CH)
    ) u_next (
        .cur      (cur_ch_q),
        .mask     (ch_mask),
        .next_idx (find_idx_s),
        .found    (find_ok_s),
        .wrapped  (find_wrap_s)
    );

    // Next-state, channel choice, dwell counting and output data selection.
    always_comb begin
        state_d   = state_q;
        ch_next_s = cur_ch_q;
        cnt_d     = '0;
        wrap_d    = 1'b0;
        valid_d   = 1'b0;
        case (mode_t'(mode))
            MODE_MANUAL: begin
                state_d = S_MANUAL;
                if (sel_ok_s) begin
                    ch_next_s = sel;
                    valid_d   = 1'b1;
                end else begin
                    ch_next_s = cur_ch_q;
                    valid_d   = 1'b0;
                end
            end
            MODE_SCAN: begin
                state_d = S_SCAN;
                if (!find_ok_s) begin
                    // No channel enabled: park on the current index with no data.
                    ch_next_s = cur_ch_q;
                    valid_d   = 1'b0;
                end else if (state_q == S_MANUAL) begin
                    // Entry into scan: stay put if allowed, never flag a wrap.
                    valid_d   = 1'b1;
                    ch_next_s = ch_mask[cur_ch_q] ? cur_ch_q : find_idx_s;
                end else if (!ch_mask[cur_ch_q]) begin
                    // Current channel dropped out of rotation: leave immediately.
                    valid_d   = 1'b1;
                    ch_next_s = find_idx_s;
                    wrap_d    = find_wrap_s;
                end else if (hold) begin
                    valid_d   = 1'b1;
                    cnt_d     = cnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    valid_d   = 1'b1;
                    ch_next_s = find_idx_s;
                    wrap_d    = find_wrap_s;
                end else begin
                    valid_d   = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_MANUAL;
                ch_next_s = cur_ch_q;
                valid_d   = 1'b0;
            end
        endcase
        data_out_d = valid_d ? data_in[int'(ch_next_s)*WIDTH +: WIDTH] : '0;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_MANUAL;
            cur_ch_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_ch_q   <= ch_next_s;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            cnt_q      <= cnt_d;
        end
    end

    assign data_out = data_out_q;
    assign cur_ch   = cur_ch_q;
    assign valid    = valid_q;
    assign wrap     = wrap_q;

endmodule
